// File: rtl/stream_decoder.sv
// rtl/stream_decoder.sv - counts ones of a stochastic bitstream over a 2^LOG_LEN window (STREAM_DECODER_BIPOLAR_EN selects signed output)
module stream_decoder #(
    parameter int LOG_LEN = 8,
    parameter int OFFSET  = 0
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               x,
    input  logic               start,
    input  logic               ready,
    output logic               busy,
    output logic               valid,
    output logic [LOG_LEN+1:0] value
);
    localparam int L = 1 << LOG_LEN;

    typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

    state_t             state;
    logic [LOG_LEN:0]   ones_cnt;
    logic [LOG_LEN-1:0] cyc_cnt;
    logic [LOG_LEN:0]   ones_next;
    logic [LOG_LEN+1:0] result;
    logic [31:0]        unused_offset;

    assign unused_offset = OFFSET;
    assign ones_next     = ones_cnt + {{LOG_LEN{1'b0}}, x};

`ifdef STREAM_DECODER_BIPOLAR_EN
    // 2*count - L; LOG_LEN+2 bits holds both +L and -L
    assign result = {ones_next, 1'b0} - (LOG_LEN+2)'(L);
`else
    assign result = {1'b0, ones_next};
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            valid    <= 1'b0;
            value    <= '0;
            ones_cnt <= '0;
            cyc_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= COUNT;
                        busy     <= 1'b1;
                        ones_cnt <= '0;
                        cyc_cnt  <= '0;
                    end
                end
                COUNT: begin
                    ones_cnt <= ones_next;
                    cyc_cnt  <= cyc_cnt + LOG_LEN'(1);
                    // all-ones cycle count marks the L-th sample
                    if (&cyc_cnt) begin
                        state <= HOLD;
                        busy  <= 1'b0;
                        valid <= 1'b1;
                        value <= result;
                    end
                end
                HOLD: begin
                    if (ready) begin
                        valid <= 1'b0;
                        if (start) begin
                            state    <= COUNT;
                            busy     <= 1'b1;
                            ones_cnt <= '0;
                            cyc_cnt  <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stream_decoder.sv
// tb/tb_stream_decoder.sv - randomized self-checking bench for stream_decoder at LOG_LEN=4
module tb_stream_decoder;
    localparam int LOG_LEN = 4;
    localparam int L       = 16;

    logic             clk = 1'b0;
    logic             n_rst;
    logic             x;
    logic             start;
    logic             ready;
    logic             busy;
    logic             valid;
    logic [LOG_LEN+1:0] value;

    int total  = 0;
    int passed = 0;

    stream_decoder #(.LOG_LEN(LOG_LEN), .OFFSET(0)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .x     (x),
        .start (start),
        .ready (ready),
        .busy  (busy),
        .valid (valid),
        .value (value)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [5:0] expect_val(input int ones);
`ifdef STREAM_DECODER_BIPOLAR_EN
        return 6'(2 * ones - L);
`else
        return 6'(ones);
`endif
    endfunction

    // mode: 0 all zero, 1 all one, 2 alternating from 1, else random
    task automatic run_window(input int mode, input bit noisy, input bit do_start,
                              output logic [5:0] exp);
        int ones;
        bit count_ok;
        ones     = 0;
        count_ok = 1'b1;
        if (do_start) begin
            start = 1'b1;
            step();
            start = 1'b0;
        end
        check("busy_after_start", {busy, valid}, 2'b10);
        for (int i = 0; i < L; i++) begin
            case (mode)
                0:       x = 1'b0;
                1:       x = 1'b1;
                2:       x = (i % 2 == 0);
                default: x = 1'($urandom_range(0, 1));
            endcase
            if (noisy) start = 1'($urandom_range(0, 1));
            ones += int'(x);
            step();
            if (i < L - 1 && {busy, valid} !== 2'b10) count_ok = 1'b0;
        end
        start = 1'b0;
        exp   = expect_val(ones);
        check("busy_whole_window", 32'(count_ok), 32'd1);
        check("done_flags", {busy, valid}, 2'b01);
        check("result_value", value, exp);
    endtask

    task automatic ack(input logic [5:0] exp);
        ready = 1'b1;
        step();
        ready = 1'b0;
        check("ack_flags", {busy, valid}, 2'b00);
        check("ack_value_kept", value, exp);
    endtask

    initial begin
        logic [5:0] exp;
        bit         seen;
        n_rst = 1'b0;
        x     = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        #3;
        check("reset_busy", busy, 1'b0);
        check("reset_valid", valid, 1'b0);
        check("reset_value", value, 6'd0);
        step();
        n_rst = 1'b1;

        run_window(1, 1'b0, 1'b1, exp);
        check("ones_const", exp, expect_val(L));

        // consumer stalls: result must hold
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_flags", {busy, valid}, 2'b01);
            check("stall_value", value, exp);
        end
        ack(exp);
        step();
        check("idle_stays", {busy, valid}, 2'b00);

        run_window(2, 1'b0, 1'b1, exp);
        ack(exp);

        run_window(0, 1'b0, 1'b1, exp);
        // handshake and restart on the same edge
        ready = 1'b1;
        start = 1'b1;
        step();
        ready = 1'b0;
        start = 1'b0;
        run_window(3, 1'b1, 1'b0, exp);
        ack(exp);

        for (int w = 0; w < 4; w++) begin
            run_window(3, (w % 2) == 1, 1'b1, exp);
            for (int d = 0; d < int'($urandom_range(0, 3)); d++) step();
            check("rand_hold_valid", valid, 1'b1);
            ack(exp);
        end

        // reset partway through a window
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            x = 1'b1;
            step();
        end
        #2;
        n_rst = 1'b0;
        #1;
        check("midreset_flags", {busy, valid}, 2'b00);
        check("midreset_value", value, 6'd0);
        step();
        step();
        n_rst = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        check("no_result_after_reset", 32'(seen), 32'd0);
        run_window(3, 1'b0, 1'b1, exp);
        ack(exp);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
